// File: rtl/n_bit_adder_pkg.sv
// Shared constants for the ripple-carry adder primitive.
package n_bit_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as one link of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/n_bit_adder.sv
// N-bit ripple-carry adder with a zero-latency result path and a
// one-cycle registered copy of sum, carry-out and signed overflow.
module n_bit_adder
    import n_bit_adder_pkg::*;
#(
    parameter int unsigned N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow,
    output logic [N-1:0] sum_q,
    output logic         c_out_q,
    output logic         ovf_q
);

    // carry[i] enters bit i; carry[N] leaves the MSB
    logic [N:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_chain
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign c_out    = carry[N];
    // Signed overflow: carry into the MSB disagrees with carry out of it
    assign overflow = carry[N-1] ^ carry[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= sum;
            c_out_q <= c_out;
            ovf_q   <= overflow;
        end
    end

endmodule

// File: tb/tb_n_bit_adder.sv
// Self-checking bench for n_bit_adder (N = 8): directed table, sweep,
// random vectors against an arithmetic model, and registered-path corners.
module tb_n_bit_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic         cin_r;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic [W-1:0] sum_q;
    logic         c_out_q;
    logic         ovf_q;

    int n_cmp;
    int n_bad;

    n_bit_adder #(.N(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (a_r),
        .B        (b_r),
        .c_in     (cin_r),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow),
        .sum_q    (sum_q),
        .c_out_q  (c_out_q),
        .ovf_q    (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    // Reference: plain integer arithmetic in unsigned and signed views
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        res_t r;
        int   u;
        int   sv;
        u   = int'(a) + int'(b) + int'(cin);
        sv  = int'($signed(a)) + int'($signed(b)) + int'(cin);
        r.s = W'(u);
        r.c = (u >= 256);
        r.v = (sv > 127) || (sv < -128);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_comb(input string tag, input res_t e);
        check({tag, ".sum"}, 32'(sum), 32'(e.s));
        check({tag, ".c_out"}, 32'(c_out), 32'(e.c));
        check({tag, ".overflow"}, 32'(overflow), 32'(e.v));
    endtask

    task automatic check_q(input string tag, input res_t e);
        check({tag, ".sum_q"}, 32'(sum_q), 32'(e.s));
        check({tag, ".c_out_q"}, 32'(c_out_q), 32'(e.c));
        check({tag, ".ovf_q"}, 32'(ovf_q), 32'(e.v));
    endtask

    vec_t vecs[4];
    res_t zero_r;
    res_t e;

    initial begin
        int a_i;
        int b_i;

        n_cmp  = 0;
        n_bad  = 0;
        zero_r = '{s: '0, c: 1'b0, v: 1'b0};

        vecs[0] = '{a: 8'd5,   b: 8'd3,    cin: 1'b0, exp_sum: 8'd8,    exp_cout: 1'b0, exp_ovf: 1'b0};
        vecs[1] = '{a: 8'd30,  b: 8'hF6,   cin: 1'b0, exp_sum: 8'h14,   exp_cout: 1'b1, exp_ovf: 1'b0};
        vecs[2] = '{a: 8'd5,   b: 8'hF6,   cin: 1'b1, exp_sum: 8'hFC,   exp_cout: 1'b0, exp_ovf: 1'b0};
        vecs[3] = '{a: 8'd127, b: 8'd1,    cin: 1'b0, exp_sum: 8'h80,   exp_cout: 1'b0, exp_ovf: 1'b1};

        rst_n = 1'b0;
        a_r   = '0;
        b_r   = '0;
        cin_r = 1'b0;
        #2;
        check_q("reset", zero_r);

        // Directed table
        foreach (vecs[k]) begin
            a_r   = vecs[k].a;
            b_r   = vecs[k].b;
            cin_r = vecs[k].cin;
            #2;
            check($sformatf("vec%0d.sum", k), 32'(sum), 32'(vecs[k].exp_sum));
            check($sformatf("vec%0d.c_out", k), 32'(c_out), 32'(vecs[k].exp_cout));
            check($sformatf("vec%0d.overflow", k), 32'(overflow), 32'(vecs[k].exp_ovf));
        end

        // Reset held: registered outputs stay cleared across edges
        @(posedge clk);
        #1;
        check_q("reset_hold", zero_r);

        // Sweep alternating c_in
        a_i = 5;
        b_i = 3;
        for (int s = 0; s < 10; s++) begin
            a_i   = (a_i + 17) % 256 - 128;
            b_i   = (b_i - 23) % 256 - 128;
            a_r   = W'(a_i);
            b_r   = W'(b_i);
            cin_r = s[0];
            #1;
            check_comb($sformatf("sweep%0d", s), model(a_r, b_r, cin_r));
        end

        // Release reset away from the edge, then load a known value
        @(negedge clk);
        rst_n = 1'b1;
        a_r   = 8'd5;
        b_r   = 8'd3;
        cin_r = 1'b0;
        @(posedge clk);
        #1;
        check_q("first_capture", model(8'd5, 8'd3, 1'b0));

        // Wrap-around through the register: old value held until the edge
        a_r   = 8'hFF;
        b_r   = 8'h00;
        cin_r = 1'b1;
        #2;
        check_comb("wrap", '{s: 8'h00, c: 1'b1, v: 1'b0});
        check_q("wrap_pre_edge", '{s: 8'd8, c: 1'b0, v: 1'b0});
        @(posedge clk);
        #1;
        check_q("wrap_post_edge", '{s: 8'h00, c: 1'b1, v: 1'b0});

        // Overflow through the register, then an async reset mid-cycle
        a_r   = 8'd127;
        b_r   = 8'd1;
        cin_r = 1'b0;
        @(posedge clk);
        #1;
        check_q("ovf_capture", '{s: 8'h80, c: 1'b0, v: 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        check_q("async_reset", zero_r);
        check_comb("comb_in_reset", '{s: 8'h80, c: 1'b0, v: 1'b1});
        @(negedge clk);
        rst_n = 1'b1;

        // Random vectors: comb result and its one-cycle registered copy
        for (int r = 0; r < 200; r++) begin
            @(negedge clk);
            a_r   = W'($urandom);
            b_r   = W'($urandom);
            cin_r = 1'($urandom);
            e     = model(a_r, b_r, cin_r);
            #1;
            check_comb($sformatf("rnd%0d", r), e);
            @(posedge clk);
            #1;
            check_q($sformatf("rnd%0d", r), e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
